// File: rtl/smartcargo_fila_insercao.sv
// Inserts one transport request into the SmartCargo stop queue as a pickup stop plus a delivery stop.
// Define SMARTCARGO_FIT_EN to place stops by splicing between covering stops; otherwise every stop is appended.
module smartcargo_fila_insercao #(
  parameter int PROFUNDIDADE = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              clear,
  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
  // req_ready depends only on internal state, never on req_valid.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_tipo,
  input  logic [1:0]        req_origem,
  input  logic [1:0]        req_destino,
  input  logic              fila_shift,
  input  logic [1:0]        fila_dest,
  input  logic [1:0]        fila_dest_ant,
  output logic [ADDR_W-1:0] addrSecundario,
  output logic [ADDR_W-1:0] addrSecundarioAnterior,
  output logic [1:0]        in_tipo_objeto,
  output logic [1:0]        in_origem_objeto,
  output logic [1:0]        in_destino_objeto,
  output logic              weT,
  output logic              fit,
  output logic [ADDR_W:0]   ocupacao,
  output logic              ocupado
);

`ifdef SMARTCARGO_FIT_EN
  localparam bit FIT_EN = 1'b1;
`else
  localparam bit FIT_EN = 1'b0;
`endif
  localparam logic [ADDR_W:0] LIMITE = (ADDR_W+1)'(PROFUNDIDADE - 2);
  localparam logic [ADDR_W:0] UM     = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE, BUSCA_ORIG, GRAVA_ORIG, BUSCA_DEST, GRAVA_DEST
  } estado_t;

  estado_t         estado, estado_n, grava_alvo;
  logic [ADDR_W:0] idx, idx_n, pos, pos_n, pos_coleta, pos_coleta_n, idx_reinicio;
  logic            modo_fit, modo_fit_n;
  logic [1:0]      tipo_r, origem_r, destino_r, andar;
  logic            aceita, em_busca, em_grava, cobre, achou, wet_c, fit_c;
  logic [ADDR_W-1:0] addr;

  assign req_ready = (estado == IDLE) && (ocupacao <= LIMITE);
  assign aceita    = req_valid && req_ready;
  assign ocupado   = (estado != IDLE);
  assign em_busca  = (estado == BUSCA_ORIG) || (estado == BUSCA_DEST);
  assign em_grava  = (estado == GRAVA_ORIG) || (estado == GRAVA_DEST);
  assign grava_alvo = (estado == BUSCA_ORIG) ? GRAVA_ORIG : GRAVA_DEST;

  // The probed floor fits when it lies between the two neighbouring stops, in either travel direction.
  assign andar = (estado == BUSCA_ORIG) ? origem_r : destino_r;
  assign cobre = ((fila_dest_ant <= andar) && (andar <= fila_dest)) ||
                 ((fila_dest <= andar) && (andar <= fila_dest_ant));
  assign achou = FIT_EN && (idx < ocupacao) && cobre;

  // After a pop the pickup sits one index lower, so the delivery scan resumes right behind it.
  assign idx_reinicio = ((estado == BUSCA_ORIG) || (estado == GRAVA_ORIG) || (pos_coleta == '0))
                        ? UM : pos_coleta;

  always_comb begin
    estado_n     = estado;
    idx_n        = idx;
    pos_n        = pos;
    pos_coleta_n = pos_coleta;
    modo_fit_n   = modo_fit;
    wet_c        = 1'b0;
    fit_c        = 1'b0;
    case (estado)
      IDLE: begin
        if (aceita) begin
          estado_n = BUSCA_ORIG;
          idx_n    = UM;
        end
      end
      BUSCA_ORIG, BUSCA_DEST: begin
        if (fila_shift) begin
          idx_n = idx_reinicio;
          if ((estado == BUSCA_DEST) && (pos_coleta != '0)) pos_coleta_n = pos_coleta - UM;
        end else if (achou) begin
          modo_fit_n = 1'b1;
          pos_n      = idx;
          estado_n   = grava_alvo;
        end else if (!FIT_EN || (idx >= ocupacao)) begin
          modo_fit_n = 1'b0;
          pos_n      = ocupacao;
          estado_n   = grava_alvo;
        end else begin
          idx_n = idx + UM;
        end
      end
      GRAVA_ORIG: begin
        if (modo_fit && fila_shift) begin
          estado_n = BUSCA_ORIG;
          idx_n    = UM;
        end else begin
          wet_c    = !modo_fit;
          fit_c    = modo_fit;
          estado_n = BUSCA_DEST;
          // An append lands before the pop, so the fresh pickup ends up at pos-1.
          if (fila_shift) begin
            pos_coleta_n = (pos == '0) ? '0 : pos - UM;
            idx_n        = (pos == '0) ? UM : pos;
          end else begin
            pos_coleta_n = pos;
            idx_n        = pos + UM;
          end
        end
      end
      GRAVA_DEST: begin
        if (modo_fit && fila_shift) begin
          estado_n = BUSCA_DEST;
          idx_n    = idx_reinicio;
          if (pos_coleta != '0) pos_coleta_n = pos_coleta - UM;
        end else begin
          wet_c    = !modo_fit;
          fit_c    = modo_fit;
          estado_n = IDLE;
          idx_n    = UM;
        end
      end
      default: estado_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      estado     <= IDLE;
      idx        <= UM;
      pos        <= '0;
      pos_coleta <= '0;
      modo_fit   <= 1'b0;
      tipo_r     <= '0;
      origem_r   <= '0;
      destino_r  <= '0;
    end else begin
      estado     <= estado_n;
      idx        <= idx_n;
      pos        <= pos_n;
      pos_coleta <= pos_coleta_n;
      modo_fit   <= modo_fit_n;
      if (aceita) begin
        tipo_r    <= req_tipo;
        origem_r  <= req_origem;
        destino_r <= req_destino;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      ocupacao <= '0;
    end else begin
      case ({weT | fit, fila_shift})
        2'b10:   ocupacao <= ocupacao + UM;
        2'b01:   if (ocupacao != '0) ocupacao <= ocupacao - UM;
        default: ;
      endcase
    end
  end

  assign weT = wet_c;
  assign fit = FIT_EN ? fit_c : 1'b0;

  assign addr = em_busca ? idx[ADDR_W-1:0] : (em_grava ? pos[ADDR_W-1:0] : '0);
  assign addrSecundario         = addr;
  assign addrSecundarioAnterior = (addr == '0) ? '0 : addr - 1'b1;

  assign in_tipo_objeto    = em_grava ? tipo_r : 2'd0;
  assign in_origem_objeto  = em_grava ? origem_r : 2'd0;
  assign in_destino_objeto = (estado == GRAVA_ORIG) ? origem_r :
                             (estado == GRAVA_DEST) ? destino_r : 2'd0;

endmodule

// File: tb/tb_smartcargo_fila_insercao.sv
// Bench for smartcargo_fila_insercao: a behavioural stop-queue RAM, a list-based reference model of
// stop placement, and a scoreboard that checks every weT/fit write against the model's prediction.
module tb_smartcargo_fila_insercao;
  localparam int W = 11;  // {fit, addr[3:0], tipo, origem, destino}
`ifdef SMARTCARGO_FIT_EN
  localparam bit FIT_EN = 1'b1;
`else
  localparam bit FIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1, req_valid = 1'b0, fila_shift = 1'b0;
  logic [1:0] req_tipo = 2'd0, req_origem = 2'd0, req_destino = 2'd0;
  logic       req_ready, weT, fit, ocupado;
  logic [1:0] fila_dest, fila_dest_ant;
  logic [1:0] in_tipo_objeto, in_origem_objeto, in_destino_objeto;
  logic [3:0] addrSecundario, addrSecundarioAnterior;
  logic [4:0] ocupacao;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [5:0]   model_q[$];   // reference queue of {tipo, origem, destino}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  smartcargo_fila_insercao dut (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_tipo(req_tipo), .req_origem(req_origem), .req_destino(req_destino),
    .fila_shift(fila_shift), .fila_dest(fila_dest), .fila_dest_ant(fila_dest_ant),
    .addrSecundario(addrSecundario), .addrSecundarioAnterior(addrSecundarioAnterior),
    .in_tipo_objeto(in_tipo_objeto), .in_origem_objeto(in_origem_objeto),
    .in_destino_objeto(in_destino_objeto), .weT(weT), .fit(fit),
    .ocupacao(ocupacao), .ocupado(ocupado)
  );

  // ---------------- stop-queue RAM (weT, then shift, then fit) ----------------
  logic [5:0] ram [16];
  int         ram_n = 0;
  logic [5:0] emu_nx [16];
  int         emu_n, emu_a;

  always @(posedge clk) begin
    emu_nx = ram;
    emu_n  = ram_n;
    emu_a  = int'(addrSecundario);
    if (clear) begin
      emu_n = 0;
    end else begin
      if (weT && emu_n < 16) begin
        emu_nx[emu_n] = {in_tipo_objeto, in_origem_objeto, in_destino_objeto};
        emu_n++;
      end
      if (fila_shift && emu_n > 0) begin
        for (int k = 0; k < 15; k++) emu_nx[k] = emu_nx[k+1];
        emu_n--;
      end
      if (fit && emu_n < 16) begin
        for (int k = 15; k > 0; k--) if (k > emu_a) emu_nx[k] = emu_nx[k-1];
        emu_nx[emu_a] = {in_tipo_objeto, in_origem_objeto, in_destino_objeto};
        emu_n++;
      end
    end
    for (int k = 0; k < 16; k++) ram[k] <= emu_nx[k];
    ram_n <= emu_n;
  end

  always_comb begin
    fila_dest     = 2'd0;
    fila_dest_ant = 2'd0;
    if (int'(addrSecundario) < ram_n)         fila_dest     = ram[addrSecundario][1:0];
    if (int'(addrSecundarioAnterior) < ram_n) fila_dest_ant = ram[addrSecundarioAnterior][1:0];
  end

  // ---------------- reference model ----------------
  // First gap (after index inicio-1) whose neighbouring floors enclose f, else the tail.
  function automatic int busca(input logic [1:0] f, input int inicio);
    logic [1:0] a, b;
    for (int k = inicio; k < model_q.size(); k++) begin
      a = model_q[k-1][1:0];
      b = model_q[k][1:0];
      if (FIT_EN && ((a <= f && f <= b) || (b <= f && f <= a))) return k;
    end
    return model_q.size();
  endfunction

  task automatic prever_coleta(input logic [1:0] t, input logic [1:0] o, output int p);
    p = busca(o, 1);
    exp_q.push_back({(p < model_q.size()) ? 1'b1 : 1'b0, 4'(p), t, o, o});
    model_q.insert(p, {t, o, o});
  endtask

  task automatic prever_entrega(input logic [1:0] t, input logic [1:0] o, input logic [1:0] d,
                                input int coleta);
    int p;
    p = busca(d, (coleta + 1 < 1) ? 1 : coleta + 1);
    exp_q.push_back({(p < model_q.size()) ? 1'b1 : 1'b0, 4'(p), t, o, d});
    model_q.insert(p, {t, o, d});
  endtask

  task automatic model_pop();
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_got, mon_exp;
  always @(negedge clk) begin
    if (weT || fit) begin
      mon_got = {fit, addrSecundario, in_tipo_objeto, in_origem_objeto, in_destino_objeto};
      checks++;
      if (weT && fit) begin
        errors++;
        $display("FAIL both_pulses: weT=%0b fit=%0b, required at most one", weT, fit);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h, no write expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL ram_write: got fit=%0b addr=%0d data=%0d/%0d/%0d required fit=%0b addr=%0d data=%0d/%0d/%0d",
                   mon_got[10], mon_got[9:6], mon_got[5:4], mon_got[3:2], mon_got[1:0],
                   mon_exp[10], mon_exp[9:6], mon_exp[5:4], mon_exp[3:2], mon_exp[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nome, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nome, got, exp_v);
    end
  endtask

  task automatic do_clear();
    chk("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_q.delete();
    chk("clear_ocupacao", ocupacao, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 80) begin tick(); n++; end
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ocupado && n < 80) begin tick(); n++; end
    chk("idle_timeout", ocupado, 0);
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!(weT || fit) && n < 80) begin tick(); n++; end
    chk("pulse_timeout", weT | fit, 1);
  endtask

  task automatic enviar(input logic [1:0] t, input logic [1:0] o, input logic [1:0] d);
    req_tipo = t; req_origem = o; req_destino = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pedido(input logic [1:0] t, input logic [1:0] o, input logic [1:0] d);
    int p;
    wait_ready();
    prever_coleta(t, o, p);
    prever_entrega(t, o, d, p);
    enviar(t, o, d);
    wait_idle();
    chk("ocupacao_after_req", ocupacao, model_q.size());
  endtask

  // Request with a pop coinciding with the pickup write cycle.
  task automatic pedido_shift(input logic [1:0] t, input logic [1:0] o, input logic [1:0] d);
    int p, sz;
    wait_ready();
    sz = model_q.size();
    p  = busca(o, 1);
    if (p < sz) begin
      // The splice is cancelled and the whole placement reruns on the popped queue.
      model_pop();
      prever_coleta(t, o, p);
      prever_entrega(t, o, d, p);
    end else begin
      // The append still lands, then the pop moves it one index down.
      prever_coleta(t, o, p);
      model_pop();
      prever_entrega(t, o, d, p - 1);
    end
    enviar(t, o, d);
    wait_pulse();
    fila_shift = 1'b1;
    tick();
    fila_shift = 1'b0;
    wait_idle();
    chk("ocupacao_after_shift_req", ocupacao, model_q.size());
  endtask

  task automatic shift_tick();
    fila_shift = 1'b1;
    model_pop();
    tick();
    fila_shift = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p, nidle;

    repeat (3) tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_ocupacao", ocupacao, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_weT", weT, 0);
    chk("rst_fit", fit, 0);
    chk("rst_addr", addrSecundario, 0);
    chk("rst_addr_ant", addrSecundarioAnterior, 0);
    chk("rst_data", {in_tipo_objeto, in_origem_objeto, in_destino_objeto}, 0);
    clear = 1'b0;
    tick();

    // Empty queue latency: writes on the 2nd and 4th edges after accept, ready again after the 4th.
    prever_coleta(2'd1, 2'd0, p);
    prever_entrega(2'd1, 2'd0, 2'd3, p);
    enviar(2'd1, 2'd0, 2'd3);
    chk("lat_busca_orig_ready", req_ready, 0);
    chk("lat_busca_orig_weT", weT, 0);
    chk("lat_busca_orig_ocupado", ocupado, 1);
    tick();
    chk("lat_grava_orig_weT", weT, 1);
    chk("lat_grava_orig_addr", addrSecundario, 0);
    tick();
    chk("lat_busca_dest_weT", weT, 0);
    tick();
    chk("lat_grava_dest_weT", weT, 1);
    chk("lat_grava_dest_addr", addrSecundario, 1);
    chk("lat_grava_dest_addr_ant", addrSecundarioAnterior, 0);
    tick();
    chk("lat_ready_back", req_ready, 1);
    chk("lat_ocupado", ocupado, 0);
    chk("lat_ocupacao", ocupacao, 2);

    // Queue destinos [3,0], then a request whose floors sit inside that span.
    do_clear();
    pedido(2'd2, 2'd3, 2'd0);
    pedido(2'd1, 2'd1, 2'd2);

    // Queue destinos [0,1], then a pickup floor no span covers.
    do_clear();
    pedido(2'd0, 2'd0, 2'd1);
    pedido(2'd3, 2'd3, 2'd2);

    // Abort during the delivery search: pickup written, delivery never written.
    wait_ready();
    prever_coleta(2'd2, 2'd1, p);
    enviar(2'd2, 2'd1, 2'd3);
    wait_pulse();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_q.delete();
    chk("abort_ocupacao", ocupacao, 0);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_ready", req_ready, 1);
    repeat (4) tick();
    chk("abort_exp_q", exp_q.size(), 0);

    // Pop during the pickup write on a queue where the pickup would splice at index 2.
    pedido(2'd0, 2'd0, 2'd0);
    pedido(2'd0, 2'd3, 2'd0);
    pedido_shift(2'd1, 2'd1, 2'd2);

    // Pop during an appended pickup write.
    do_clear();
    pedido(2'd0, 2'd0, 2'd1);
    pedido_shift(2'd2, 2'd3, 2'd2);

    // Fill to 16 entries and check the two-entry headroom.
    do_clear();
    for (int k = 0; k < 8; k++)
      pedido(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    chk("full_ready", req_ready, 0);
    shift_tick();
    chk("ocup15_ocupacao", ocupacao, 15);
    chk("ocup15_ready", req_ready, 0);
    shift_tick();
    chk("ocup14_ocupacao", ocupacao, 14);
    chk("ocup14_ready", req_ready, 1);

    // Random traffic with pops between requests.
    for (int n = 0; n < 40; n++) begin
      nidle = $urandom_range(0, 3);
      for (int k = 0; k < nidle; k++) begin
        if (model_q.size() > 0 && $urandom_range(0, 1) == 1) shift_tick();
        else tick();
      end
      while (model_q.size() > 14) shift_tick();
      pedido(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // RAM image built from the DUT's writes must equal the reference queue.
    repeat (2) tick();
    chk("final_ram_size", ram_n, model_q.size());
    for (int k = 0; k < model_q.size(); k++) chk("final_ram_entry", ram[k], model_q[k]);
    chk("final_exp_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
